// File: rtl/multi_16_pkg.sv
// Shared types and constants for the FFT butterfly datapath: sample and
// Q1.7 coefficient formats, product widths and the output saturation helper.
package multi_16_pkg;

  localparam int SAMPLE_W  = 17;
  localparam int COEF_W    = 8;
  localparam int COEF_FRAC = 7;
  localparam int PROD_W    = 24;
  // One guard bit: (-65536) x (-128) = +2^23, which does not fit in PROD_W signed bits.
  localparam int PROD_EXT_W = PROD_W + 1;
  localparam int NUM_PP     = COEF_W / 2;

  typedef logic signed [SAMPLE_W-1:0]   sample_t;
  typedef logic signed [COEF_W-1:0]     coef_t;
  typedef logic signed [PROD_EXT_W-1:0] prod_t;

  localparam sample_t SAMPLE_MAX = 17'sh0FFFF;
  localparam sample_t SAMPLE_MIN = 17'sh10000;

  // Clamp a scaled product into the signed sample range.
  function automatic sample_t saturate(input prod_t scaled);
    sample_t res;
    if (scaled > prod_t'(SAMPLE_MAX))
      res = SAMPLE_MAX;
    else if (scaled < prod_t'(SAMPLE_MIN))
      res = SAMPLE_MIN;
    else
      res = scaled[SAMPLE_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/multi_16_booth_mul_17x8.sv
// Combinational radix-4 Booth multiplier: signed 17-bit sample times signed
// 8-bit coefficient, four partial products summed to the exact product.
module booth_mul_17x8
  import multi_16_pkg::*;
(
  input  sample_t a,
  input  coef_t   b,
  output prod_t   p
);

  logic [COEF_W:0] b_ext;
  prod_t           a_ext;
  prod_t           pp;
  prod_t           acc;

  assign b_ext = {b, 1'b0};
  assign a_ext = {{(PROD_EXT_W-SAMPLE_W){a[SAMPLE_W-1]}}, a};

  // NOTE: every variable driven here gets a value on every pass (defaults
  // first), so no latch is inferred; blocking '=' is correct in always_comb.
  always_comb begin
    acc = '0;
    pp  = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      case (b_ext[2*i+2 -: 3])
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2*i));
    end
  end

  assign p = acc;

endmodule

// File: rtl/multi_16.sv
// Two-stage signed scaling multiplier: sample x Q1.7 twiddle, floor-shifted
// back to sample format and saturated, with a valid strobe of latency 2.
module multi_16
  import multi_16_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  sample_t in_17bit,
  input  coef_t   in_8bit,
  output sample_t out,
  output logic    out_valid
);

  prod_t   prod_c;
  prod_t   prod_q;
  prod_t   scaled;
  sample_t sat_c;
  logic    v1;

  booth_mul_17x8 u_booth (
    .a (in_17bit),
    .b (in_8bit),
    .p (prod_c)
  );

  // Arithmetic shift gives truncation toward minus infinity; no rounding.
  assign scaled = prod_q >>> COEF_FRAC;
  assign sat_c  = saturate(scaled);

  // NOTE: sequential state uses non-blocking '<=' so both stages sample the
  // pre-edge values. Data registers are reset too, since out must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '0;
      v1        <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
      if (in_valid)
        prod_q <= prod_c;
      if (v1)
        out <= sat_c;
    end
  end

endmodule

// File: tb/tb_multi_16.sv
// Self-checking bench for multi_16: directed corner cases, a random stream
// with a bubble, and reset behaviour, against an arithmetic reference model.
module tb_multi_16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [16:0] in_17bit;
  logic [7:0]  in_8bit;
  logic [16:0] out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  multi_16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_17bit  (in_17bit),
    .in_8bit   (in_8bit),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, floor divide by 128, clamp to 17-bit signed.
  function automatic logic [16:0] ref_out(input logic [16:0] a, input logic [7:0] b);
    longint p;
    longint s;
    logic [16:0] r;
    p = longint'($signed(a)) * longint'($signed(b));
    s = p / 128;
    if ((p % 128) != 0 && p < 0) s = s - 1;
    if (s > 65535)  s = 65535;
    if (s < -65536) s = -65536;
    r = s[16:0];
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_17bit = 17'($urandom);
    in_8bit  = 8'($urandom);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out !== 17'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h out_valid=%b, required out=00000 out_valid=0", out, out_valid);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_directed();
    logic [16:0] va [7];
    logic [7:0]  vb [7];
    logic [16:0] ve [7];
    va[0] = 17'h01108; vb[0] = 8'h7F; ve[0] = 17'h010E5;
    va[1] = 17'h00100; vb[1] = 8'h7F; ve[1] = 17'h000FE;
    va[2] = 17'h00000; vb[2] = 8'($urandom); ve[2] = 17'h00000;
    va[3] = 17'h10000; vb[3] = 8'h80; ve[3] = 17'h0FFFF;
    va[4] = 17'h10000; vb[4] = 8'h7F; ve[4] = 17'h10200;
    va[5] = 17'h1FFFF; vb[5] = 8'h01; ve[5] = 17'h1FFFF;
    va[6] = 17'h00001; vb[6] = 8'h01; ve[6] = 17'h00000;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_17bit = va[i];
      in_8bit  = vb[i];
      @(negedge clk);
      in_valid = 1'b0;
      in_17bit = 17'($urandom);
      in_8bit  = 8'($urandom);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d_early: out_valid=%b after 1 edge, required 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out !== ve[i]) begin
        errors++;
        $display("FAIL directed_%0d: %h x %h gave out=%h out_valid=%b, required out=%h out_valid=1",
                 i, va[i], vb[i], out, out_valid, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_v [11];
    logic [16:0] exp_o [11];
    logic [16:0] last_out;
    int          bubble_pos;
    bubble_pos = int'($urandom_range(1, 7));
    last_out   = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (out_valid !== exp_v[k-2]) begin
          errors++;
          $display("FAIL stream_valid_%0d: out_valid=%b, required %b", k-2, out_valid, exp_v[k-2]);
        end
        if (exp_v[k-2]) last_out = exp_o[k-2];
        checks++;
        if (out !== last_out) begin
          errors++;
          $display("FAIL stream_data_%0d: out=%h, required %h", k-2, out, last_out);
        end
      end
      in_17bit = 17'($urandom);
      in_8bit  = 8'($urandom);
      in_valid = (k < 9) && (k != bubble_pos);
      exp_v[k] = in_valid;
      exp_o[k] = ref_out(in_17bit, in_8bit);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    logic [16:0] a;
    logic [7:0]  b;
    @(negedge clk);
    in_valid = 1'b1;
    in_17bit = 17'h10000;
    in_8bit  = 8'h80;
    @(negedge clk);
    rst      = 1'b1;
    in_17bit = 17'h01108;
    in_8bit  = 8'h7F;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out !== 17'h0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_flush_%0d: out=%h out_valid=%b, required out=00000 out_valid=0", i, out, out_valid);
      end
      @(negedge clk);
    end
    a = 17'($urandom);
    b = 8'($urandom);
    in_valid = 1'b1;
    in_17bit = a;
    in_8bit  = b;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_refill_early: out_valid=%b, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out !== ref_out(a, b)) begin
      errors++;
      $display("FAIL reset_refill: out=%h out_valid=%b, required out=%h out_valid=1", out, out_valid, ref_out(a, b));
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_17bit = '0;
    in_8bit  = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
